// File: rtl/crc_checker.sv
// Receive-side CRC checker: latches a {data, crc} codeword, recomputes the CRC
// over the data field a chunk per clock, and reports data plus a pass/fail flag.
module crc_checker #(
  parameter int unsigned           DATA_WIDTH        = 56,
  parameter int unsigned           CRC_WIDTH         = 8,
  parameter logic [CRC_WIDTH:0]    POLY              = 9'h187,
  parameter logic [CRC_WIDTH-1:0]  SEED              = '0,
  parameter int unsigned           XOR_OPS_PER_CYCLE = 8,
  parameter int unsigned           ERR_CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH+CRC_WIDTH-1:0] s_codeword,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_crc_ok,
  output logic [CRC_WIDTH-1:0]            m_crc_calc,
  output logic [ERR_CNT_WIDTH-1:0]        err_count,
  input  logic                            clear_err
);

  localparam int unsigned K     = XOR_OPS_PER_CYCLE;
  localparam int unsigned STEPS = DATA_WIDTH / K;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0]     LAST = CNT_W'(STEPS - 1);
  localparam logic [CRC_WIDTH-1:0] TAPS = POLY[CRC_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [CRC_WIDTH-1:0]    crc_q;
  logic [CRC_WIDTH-1:0]    lfsr;
  logic [CRC_WIDTH-1:0]    lfsr_next;
  logic [CNT_W-1:0]        cnt;

  function automatic logic [CRC_WIDTH-1:0] fold(input logic [CRC_WIDTH-1:0] l,
                                                input logic [K-1:0] bits);
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = l;
    for (int unsigned i = 0; i < K; i++) begin
      fb = r[CRC_WIDTH-1] ^ bits[K-1-i];
      r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? TAPS : '0);
    end
    return r;
  endfunction

  // shift_q presents the next unconsumed chunk in its top K bits
  always_comb begin
    lfsr_next = fold(lfsr, shift_q[DATA_WIDTH-1 -: K]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_valid && s_ready) state_next = CALC;
      CALC:    if (cnt == LAST)        state_next = DONE;
      DONE:    if (m_valid && m_ready) state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_crc_ok   <= 1'b0;
      m_crc_calc <= '0;
      data_q     <= '0;
      shift_q    <= '0;
      crc_q      <= '0;
      lfsr       <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!s_ready) begin
            s_ready <= 1'b1;
          end else if (s_valid) begin
            data_q  <= s_codeword[DATA_WIDTH+CRC_WIDTH-1:CRC_WIDTH];
            shift_q <= s_codeword[DATA_WIDTH+CRC_WIDTH-1:CRC_WIDTH];
            crc_q   <= s_codeword[CRC_WIDTH-1:0];
            lfsr    <= SEED;
            cnt     <= '0;
            s_ready <= 1'b0;
          end
        end
        CALC: begin
          lfsr    <= lfsr_next;
          shift_q <= shift_q << K;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            m_valid    <= 1'b1;
            m_data     <= data_q;
            m_crc_calc <= lfsr_next;
            m_crc_ok   <= (lfsr_next == crc_q);
          end
        end
        DONE: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // clear_err wins over a coincident failing handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (m_valid && m_ready && !m_crc_ok && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
